// File: rtl/snow64_vector_alu_sequencer.sv
// Vector ALU sequencer: walks a latched 256-bit operand pair one element per cycle
// through a width-specific ALU and assembles the result vector.

module snow64_alu_core #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned WIDTH__OPER = 4
) (
    input  logic [WIDTH__OPER-1:0] oper,
    input  logic                   unsgn_or_sgn,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic [WIDTH-1:0]       result
);
    typedef enum logic [WIDTH__OPER-1:0] {
        OP_ADD       = 0,
        OP_SUB       = 1,
        OP_SLT       = 2,
        OP_AND       = 5,
        OP_ORR       = 6,
        OP_XOR       = 7,
        OP_SHL       = 8,
        OP_SHR       = 9,
        OP_INV       = 10,
        OP_NOT       = 11,
        OP_ADD_AGAIN = 12
    } op_t;

    logic signed [WIDTH-1:0] sra;
    logic                    slt;

    always_comb begin
        // Kept in a signed variable so >>> stays arithmetic for any shift amount
        sra    = $signed(a) >>> b;
        slt    = unsgn_or_sgn ? ($signed(a) < $signed(b)) : (a < b);
        result = '0;
        case (oper)
            OP_ADD, OP_ADD_AGAIN: result = a + b;
            OP_SUB:               result = a - b;
            OP_SLT:               result = {{(WIDTH-1){1'b0}}, slt};
            OP_AND:               result = a & b;
            OP_ORR:               result = a | b;
            OP_XOR:               result = a ^ b;
            OP_SHL:               result = a << b;
            OP_SHR:               result = unsgn_or_sgn ? $unsigned(sra) : (a >> b);
            OP_INV:               result = ~a;
            OP_NOT:               result = {{(WIDTH-1){1'b0}}, (a == '0)};
            default:              result = '0;
        endcase
    end
endmodule

module Snow64Alu8 #(parameter int unsigned WIDTH__OPER = 4) (
    input  logic [WIDTH__OPER-1:0] oper,
    input  logic                   unsgn_or_sgn,
    input  logic [7:0]             a,
    input  logic [7:0]             b,
    output logic [7:0]             result
);
    snow64_alu_core #(.WIDTH(8), .WIDTH__OPER(WIDTH__OPER)) core (
        .oper(oper), .unsgn_or_sgn(unsgn_or_sgn), .a(a), .b(b), .result(result)
    );
endmodule

module Snow64Alu16 #(parameter int unsigned WIDTH__OPER = 4) (
    input  logic [WIDTH__OPER-1:0] oper,
    input  logic                   unsgn_or_sgn,
    input  logic [15:0]            a,
    input  logic [15:0]            b,
    output logic [15:0]            result
);
    snow64_alu_core #(.WIDTH(16), .WIDTH__OPER(WIDTH__OPER)) core (
        .oper(oper), .unsgn_or_sgn(unsgn_or_sgn), .a(a), .b(b), .result(result)
    );
endmodule

module Snow64Alu32 #(parameter int unsigned WIDTH__OPER = 4) (
    input  logic [WIDTH__OPER-1:0] oper,
    input  logic                   unsgn_or_sgn,
    input  logic [31:0]            a,
    input  logic [31:0]            b,
    output logic [31:0]            result
);
    snow64_alu_core #(.WIDTH(32), .WIDTH__OPER(WIDTH__OPER)) core (
        .oper(oper), .unsgn_or_sgn(unsgn_or_sgn), .a(a), .b(b), .result(result)
    );
endmodule

module Snow64Alu64 #(parameter int unsigned WIDTH__OPER = 4) (
    input  logic [WIDTH__OPER-1:0] oper,
    input  logic                   unsgn_or_sgn,
    input  logic [63:0]            a,
    input  logic [63:0]            b,
    output logic [63:0]            result
);
    snow64_alu_core #(.WIDTH(64), .WIDTH__OPER(WIDTH__OPER)) core (
        .oper(oper), .unsgn_or_sgn(unsgn_or_sgn), .a(a), .b(b), .result(result)
    );
endmodule

module snow64_vector_alu_sequencer #(
    parameter int unsigned WIDTH__VECTOR = 256,
    parameter int unsigned WIDTH__OPER   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_start,
    input  logic [WIDTH__OPER-1:0]   in_oper,
    input  logic                     in_unsgn_or_sgn,
    input  logic [1:0]               in_int_type_size,
    input  logic [WIDTH__VECTOR-1:0] in_a,
    input  logic [WIDTH__VECTOR-1:0] in_b,
    output logic                     out_busy,
    output logic                     out_valid,
    output logic [WIDTH__VECTOR-1:0] out_data
);
    localparam int unsigned N8    = WIDTH__VECTOR / 8;
    localparam int unsigned N16   = WIDTH__VECTOR / 16;
    localparam int unsigned N32   = WIDTH__VECTOR / 32;
    localparam int unsigned N64   = WIDTH__VECTOR / 64;
    localparam int unsigned CNT_W = $clog2(N8);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state;
    logic [WIDTH__VECTOR-1:0] a_q, b_q, work, work_next;
    logic [WIDTH__OPER-1:0]   oper_q;
    logic                     sgn_q;
    logic [1:0]               size_q;
    logic [CNT_W-1:0]         counter, last_idx;
    logic                     last;
    int unsigned              i8, i16, i32, i64;
    logic [7:0]               r8;
    logic [15:0]              r16;
    logic [31:0]              r32;
    logic [63:0]              r64;

    // Wider ALUs see the counter wrapped to their lane count so their slices stay in range
    always_comb begin
        i8  = 32'(counter);
        i16 = i8 % N16;
        i32 = i8 % N32;
        i64 = i8 % N64;
    end

    Snow64Alu8 #(.WIDTH__OPER(WIDTH__OPER)) alu8 (
        .oper(oper_q), .unsgn_or_sgn(sgn_q),
        .a(a_q[i8*8 +: 8]), .b(b_q[i8*8 +: 8]), .result(r8)
    );
    Snow64Alu16 #(.WIDTH__OPER(WIDTH__OPER)) alu16 (
        .oper(oper_q), .unsgn_or_sgn(sgn_q),
        .a(a_q[i16*16 +: 16]), .b(b_q[i16*16 +: 16]), .result(r16)
    );
    Snow64Alu32 #(.WIDTH__OPER(WIDTH__OPER)) alu32 (
        .oper(oper_q), .unsgn_or_sgn(sgn_q),
        .a(a_q[i32*32 +: 32]), .b(b_q[i32*32 +: 32]), .result(r32)
    );
    Snow64Alu64 #(.WIDTH__OPER(WIDTH__OPER)) alu64 (
        .oper(oper_q), .unsgn_or_sgn(sgn_q),
        .a(a_q[i64*64 +: 64]), .b(b_q[i64*64 +: 64]), .result(r64)
    );

    always_comb begin
        work_next = work;
        last_idx  = '0;
        case (size_q)
            2'd0: begin work_next[i8*8 +: 8]    = r8;  last_idx = CNT_W'(N8 - 1);  end
            2'd1: begin work_next[i16*16 +: 16] = r16; last_idx = CNT_W'(N16 - 1); end
            2'd2: begin work_next[i32*32 +: 32] = r32; last_idx = CNT_W'(N32 - 1); end
            default: begin work_next[i64*64 +: 64] = r64; last_idx = CNT_W'(N64 - 1); end
        endcase
        last = (counter == last_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_busy  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            counter   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            oper_q    <= '0;
            sgn_q     <= 1'b0;
            size_q    <= '0;
            work      <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (in_start) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        oper_q   <= in_oper;
                        sgn_q    <= in_unsgn_or_sgn;
                        size_q   <= in_int_type_size;
                        counter  <= '0;
                        out_busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work    <= work_next;
                    counter <= counter + 1'b1;
                    if (last) begin
                        out_data  <= work_next;
                        out_busy  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snow64_vector_alu_sequencer.sv
// Self-checking bench: directed scenarios plus randomized ops against a per-element arithmetic model.

module tb_snow64_vector_alu_sequencer;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_start;
    logic [3:0]   in_oper;
    logic         in_unsgn_or_sgn;
    logic [1:0]   in_int_type_size;
    logic [255:0] in_a, in_b;
    logic         out_busy, out_valid;
    logic [255:0] out_data;

    int unsigned  n_checks = 0;
    int unsigned  n_pass   = 0;
    int unsigned  n_fail   = 0;
    logic [255:0] prev_data = '0;

    snow64_vector_alu_sequencer #(.WIDTH__VECTOR(256), .WIDTH__OPER(4)) dut (
        .clk(clk), .rst(rst), .in_start(in_start), .in_oper(in_oper),
        .in_unsgn_or_sgn(in_unsgn_or_sgn), .in_int_type_size(in_int_type_size),
        .in_a(in_a), .in_b(in_b), .out_busy(out_busy), .out_valid(out_valid),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r = '0;
        for (int unsigned i = 0; i < 8; i++) r = {r[223:0], $urandom()};
        return r;
    endfunction

    function automatic logic [255:0] small_b(input logic [1:0] sz);
        int unsigned  w = 8 << sz;
        logic [255:0] r = '0;
        for (int unsigned i = 0; i < 256 / w; i++)
            r = r | (256'($urandom_range(0, w + 1)) << (i * w));
        return r;
    endfunction

    // Reference: each element evaluated separately in 64-bit arithmetic then masked to W bits
    function automatic logic [255:0] model(input logic [3:0] op, input logic sg, input logic [1:0] sz,
                                           input logic [255:0] a, input logic [255:0] b);
        int unsigned  w    = 8 << sz;
        logic [63:0]  mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        logic [255:0] r    = '0;
        for (int unsigned i = 0; i < 256 / w; i++) begin
            logic [63:0] ea, eb, er;
            longint      sa, sb;
            ea = 64'(a >> (i * w)) & mask;
            eb = 64'(b >> (i * w)) & mask;
            sa = $signed(ea << (64 - w)) >>> (64 - w);
            sb = $signed(eb << (64 - w)) >>> (64 - w);
            case (op)
                4'd0, 4'd12: er = ea + eb;
                4'd1:  er = ea - eb;
                4'd2:  er = 64'(sg ? (sa < sb) : (ea < eb));
                4'd5:  er = ea & eb;
                4'd6:  er = ea | eb;
                4'd7:  er = ea ^ eb;
                4'd8:  er = (eb >= w) ? '0 : (ea << eb);
                4'd9:  if (sg) er = (eb >= w) ? ((sa < 0) ? '1 : '0) : 64'(sa >>> eb);
                       else    er = (eb >= w) ? '0 : (ea >> eb);
                4'd10: er = ~ea;
                4'd11: er = 64'(ea == 0);
                default: er = '0;
            endcase
            r = r | (256'(er & mask) << (i * w));
        end
        return r;
    endfunction

    task automatic launch(input logic [3:0] op, input logic sg, input logic [1:0] sz,
                          input logic [255:0] a, input logic [255:0] b);
        in_oper = op; in_unsgn_or_sgn = sg; in_int_type_size = sz;
        in_a = a; in_b = b; in_start = 1'b1;
    endtask

    // Called just after launch; returns #1 after the edge that raised out_valid
    task automatic wait_result(input string tag, input logic [1:0] sz, input logic [255:0] exp, input bit poke);
        int unsigned n = 256 / (8 << sz);
        int unsigned cyc = 0, busy_cnt = 0;
        @(posedge clk); #1;
        in_start = 1'b0;
        in_a = rand256(); in_b = rand256();
        in_oper = 4'($urandom()); in_int_type_size = 2'($urandom()); in_unsgn_or_sgn = 1'($urandom());
        while (out_valid !== 1'b1 && cyc < n + 4) begin
            if (out_busy === 1'b1) busy_cnt++;
            in_start = (poke && cyc == 2);
            if (cyc == 1) check({tag, " hold"}, out_data, prev_data);
            @(posedge clk); #1;
            cyc++;
        end
        in_start = 1'b0;
        check({tag, " latency"}, 256'(cyc), 256'(n));
        check({tag, " busy_cycles"}, 256'(busy_cnt), 256'(n));
        check({tag, " data"}, out_data, exp);
        check({tag, " busy_at_valid"}, 256'(out_busy), 256'(0));
        prev_data = exp;
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        check({tag, " after_done"}, {out_busy, out_valid, out_data}, {2'b00, prev_data});
    endtask

    initial begin
        logic [255:0] a, b, e;
        logic [3:0]   op;
        logic [1:0]   sz;
        logic         sg;
        int unsigned  vcount, bcount;

        rst = 1'b1; in_start = 1'b0; in_oper = '0; in_unsgn_or_sgn = 1'b0;
        in_int_type_size = '0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("reset_idle", {out_busy, out_valid, out_data}, '0);
            @(posedge clk); #1;
        end

        launch(4'd0, 1'b0, 2'd0, {32{8'hFF}}, {32{8'h01}});
        wait_result("add8_wrap", 2'd0, '0, 1'b0);
        idle_check("add8_wrap");

        launch(4'd9, 1'b1, 2'd3,
               {64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h8000_0000_0000_0000},
               {64'd64, 64'd63, 64'd1, 64'd4});
        wait_result("shr64_sgn", 2'd3,
                    {64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8, 64'hF800_0000_0000_0000}, 1'b0);
        idle_check("shr64_sgn");

        a = {{15{16'h1234}}, 16'hFFFF};
        b = {{15{16'h1234}}, 16'h0001};
        launch(4'd2, 1'b0, 2'd1, a, b);
        wait_result("slt16_uns", 2'd1, '0, 1'b0);
        idle_check("slt16_uns");
        launch(4'd2, 1'b1, 2'd1, a, b);
        wait_result("slt16_sgn", 2'd1, 256'd1, 1'b0);
        idle_check("slt16_sgn");

        a = rand256(); b = rand256();
        launch(4'd7, 1'b0, 2'd2, a, b);
        wait_result("start_in_run", 2'd2, a ^ b, 1'b1);
        idle_check("start_in_run");

        a = rand256(); b = rand256();
        launch(4'd6, 1'b0, 2'd2, a, b);
        wait_result("b2b_first", 2'd2, a | b, 1'b0);
        launch(4'd1, 1'b0, 2'd2, {8{32'd5}}, {8{32'd7}});
        wait_result("b2b_sub32", 2'd2, {8{32'hFFFF_FFFE}}, 1'b0);
        idle_check("b2b_sub32");

        // Reset during the fifth RUN cycle of an 8-bit op
        launch(4'd0, 1'b0, 2'd0, rand256(), rand256());
        @(posedge clk); #1;
        in_start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_run", {out_busy, out_valid, out_data}, '0);
        vcount = 0; bcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) vcount++;
            if (out_busy === 1'b1) bcount++;
        end
        check("rst_no_valid", {224'd0, vcount}, {224'd0, 32'd0});
        check("rst_no_busy", {224'd0, bcount}, {224'd0, 32'd0});
        prev_data = '0;

        // Reset coincident with start drops the start
        launch(4'd0, 1'b0, 2'd3, rand256(), rand256());
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_start = 1'b0;
        check("rst_with_start", {out_busy, out_valid, out_data}, '0);
        @(posedge clk); #1;
        check("rst_with_start_next", {out_busy, out_valid, out_data}, '0);

        a = rand256(); b = rand256();
        launch(4'd12, 1'b0, 2'd0, a, b);
        wait_result("after_rst", 2'd0, model(4'd12, 1'b0, 2'd0, a, b), 1'b0);
        idle_check("after_rst");

        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 15));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom());
            a  = rand256();
            b  = ((op == 4'd8 || op == 4'd9) && ($urandom() % 4 != 0)) ? small_b(sz) : rand256();
            if (op == 4'd11 && ($urandom() % 2 == 0)) a = a & rand256() & rand256() & rand256();
            e  = model(op, sg, sz, a, b);
            launch(op, sg, sz, a, b);
            wait_result($sformatf("rand%0d_op%0d_sz%0d_s%0d", i, op, sz, sg), sz, e, i % 5 == 0);
            idle_check($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/snow64_vector_alu_sequencer.md
Name: snow64_vector_alu_sequencer

Overview:
- Sequences a 256-bit vector operation through one ALU of the selected element width (8/16/32/64), one element per cycle.
- Sits between the vector-instruction decode/register read stage and writeback.
- Latches the operands and configuration on start, iterates a lane counter, assembles the 256-bit result, and pulses done.
- Internally instantiates Snow64Alu8, Snow64Alu16, Snow64Alu32 and Snow64Alu64. Only the instance matching the latched size feeds the result register.

Parameters:
- WIDTH__VECTOR, 256, vector operand/result width in bits; must be a multiple of 64.
- WIDTH__OPER, 4, ALU operation code width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_start  input  1  request to begin an operation; honoured only when out_busy=0.
- in_oper  input  WIDTH__OPER  ALU op (Add=0, Sub=1, Slt=2, And=5, Orr=6, Xor=7, Shl=8, Shr=9, Inv=10, Not=11, AddAgain=12; others yield 0).
- in_unsgn_or_sgn  input  1  0=unsigned, 1=signed (Slt, Shr).
- in_int_type_size  input  2  element size: 0=8b, 1=16b, 2=32b, 3=64b.
- in_a  input  WIDTH__VECTOR  operand A vector.
- in_b  input  WIDTH__VECTOR  operand B vector.
- out_busy  output  1  high while an operation is in progress (state RUN).
- out_valid  output  1  one-cycle pulse: out_data holds a complete result.
- out_data  output  WIDTH__VECTOR  result vector; held stable until the next accepted start completes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, out_busy=0, out_valid=0, out_data=0, lane counter=0, latched operands/config=0.
- States: IDLE, RUN, DONE.
  - IDLE: if in_start, latch in_a, in_b, in_oper, in_unsgn_or_sgn, in_int_type_size; counter<=0; go to RUN.
  - RUN: out_busy=1. Element i = counter occupies bits [(i+1)*W-1 : i*W] with W=8<<size; element 0 is the LSBs. Feed latched A/B element i to the ALU of width W, write its result into that slice of the working register, counter<=counter+1. When counter==N-1 (N=WIDTH__VECTOR/W: 32/16/8/4), copy the completed working register to out_data and go to DONE.
  - DONE: out_valid=1 for exactly this cycle, out_busy=0. An in_start here is accepted exactly as in IDLE (back-to-back, goes to RUN); otherwise go to IDLE.
- Latency: start sampled at edge k → out_valid high during the cycle after edge k+N. Throughput is one vector per N+1 cycles.
- in_start while out_busy=1 is ignored, with no side effects. Input changes during RUN have no effect; only latched values are used.
- Widths and arithmetic:
  - Arithmetic wraps modulo 2^W per element; there is no carry between elements.
  - Shift amount is the full W-bit B element; amounts ≥W give 0 (Shl, unsigned Shr) or sign fill (signed Shr).
  - Slt and Not produce 0 or 1 in the element, zero-extended to W.
- Unsupported oper codes: each element result is 0; sequencing is unchanged.
- out_data is not cleared on start; it updates only on the RUN→DONE transition.
- Reset mid-RUN: abort immediately to IDLE; out_data returns to 0; no out_valid pulse.
- Reset asserted concurrently with in_start: reset wins, and the start is dropped.

Test Plan:
- Reset then idle: out_busy=0, out_valid=0, out_data=0 for 10 cycles with in_start=0.
- 8-bit Add, A all bytes 0xFF, B all bytes 0x01, start at edge k → out_busy high for 32 cycles, out_valid pulse in cycle after edge k+32, out_data=0 (per-lane wrap, no carry).
- 64-bit signed Shr, A lanes {0x8000_0000_0000_0000, 0x10, -1, 0x7FFF...}, B lanes {4, 1, 63, 64} → {0xF800_0000_0000_0000, 0x8, all-ones, 0}; valid after edge k+4.
- 16-bit Slt, A lane0=0xFFFF, B lane0=0x0001: unsigned → lane0=0, signed → lane0=1; other lanes with A=B → 0.
- Start issued during RUN is ignored (single valid pulse); start issued in the DONE cycle begins a new 32-bit Sub, and its valid arrives 9 cycles after the first valid.
- Reset asserted at RUN cycle 5 of an 8-bit op → next cycle state IDLE, out_busy=0, out_data=0, no valid; a later start behaves normally.
